// File: rtl/scanline_fifo_filler.sv
// rtl/scanline_fifo_filler.sv - walks a frame region of memory and feeds the async pixel FIFO
module scanline_fifo_filler #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_LINE  = 320,
    parameter int LINES           = 240,
    parameter int SKID_ADDR_WIDTH = 2
) (
    input  logic                  write_clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fifo_write,
    output logic [DATA_WIDTH-1:0] fifo_write_data,
    input  logic                  fifo_can_write,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int SKID_DEPTH = 2 ** SKID_ADDR_WIDTH;
    localparam int CW         = SKID_ADDR_WIDTH + 1;
    localparam int XW         = $clog2(WORDS_PER_LINE + 1);
    localparam int YW         = $clog2(LINES + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                       state, state_next;
    logic [ADDR_WIDTH-1:0]        line_base;
    logic [ADDR_WIDTH-1:0]        stride_q;
    logic [XW-1:0]                x;
    logic [YW-1:0]                y;
    logic [CW-1:0]                reserved;
    logic [CW-1:0]                count;
    logic [SKID_ADDR_WIDTH-1:0]   wr_ptr;
    logic [SKID_ADDR_WIDTH-1:0]   rd_ptr;
    logic [DATA_WIDTH-1:0]        skid [SKID_DEPTH];
    logic                         start;
    logic                         req_fire;
    logic                         last_x;
    logic                         last_req;
    logic                         skid_push;

    assign start     = (state == IDLE) && frame_start;
    assign mem_req   = (state == FETCH) && (reserved < CW'(SKID_DEPTH));
    assign mem_addr  = line_base + ADDR_WIDTH'(x);
    assign req_fire  = mem_req && mem_ack;
    assign last_x    = (x == XW'(WORDS_PER_LINE - 1));
    assign last_req  = last_x && (y == YW'(LINES - 1));
    // Only words with a matching in-flight request enter the skid; anything else is stale.
    assign skid_push = mem_rvalid && (reserved > count);
    assign fifo_write      = (count != '0) && fifo_can_write;
    assign fifo_write_data = skid[rd_ptr];

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_next = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (req_fire && last_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (reserved == '0) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            line_base <= '0;
            stride_q  <= '0;
            x         <= '0;
            y         <= '0;
        end else if (start) begin
            line_base <= base_addr;
            stride_q  <= stride;
            x         <= '0;
            y         <= '0;
        end else if (req_fire) begin
            if (last_x) begin
                x         <= '0;
                y         <= y + YW'(1);
                line_base <= line_base + stride_q;
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            reserved <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case ({req_fire, fifo_write})
                2'b10:   reserved <= reserved + CW'(1);
                2'b01:   reserved <= reserved - CW'(1);
                default: reserved <= reserved;
            endcase
            case ({skid_push, fifo_write})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (skid_push)  wr_ptr <= wr_ptr + SKID_ADDR_WIDTH'(1);
            if (fifo_write) rd_ptr <= rd_ptr + SKID_ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge write_clk) begin
        if (skid_push) skid[wr_ptr] <= mem_rdata;
    end

endmodule

// File: tb/tb_scanline_fifo_filler.sv
// tb/tb_scanline_fifo_filler.sv - randomized scoreboard bench for scanline_fifo_filler
module tb_scanline_fifo_filler;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int WPL   = 4;
    localparam int LN    = 2;
    localparam int SAW   = 2;
    localparam int DEPTH = 4;
    localparam int N     = WPL * LN;

    logic          write_clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          fifo_write;
    logic [DW-1:0] fifo_write_data;
    logic          fifo_can_write = 1'b1;
    logic          busy;
    logic          frame_done;

    scanline_fifo_filler #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL),
        .LINES(LN), .SKID_ADDR_WIDTH(SAW)
    ) dut (
        .write_clk(write_clk), .reset(reset), .frame_start(frame_start),
        .base_addr(base_addr), .stride(stride),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fifo_write(fifo_write), .fifo_write_data(fifo_write_data),
        .fifo_can_write(fifo_can_write), .busy(busy), .frame_done(frame_done)
    );

    always #5 write_clk = ~write_clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } resp_t;

    logic [AW-1:0] exp_addr [$];
    resp_t         rq [$];
    int  req_idx = 0, push_idx = 0, done_count = 0, outstanding = 0, max_out = 0;
    int  lat_min = 1, lat_max = 1, cyc = 0, last_due = 0, due = 0;
    bit  ack_rand = 0, cw_rand = 0, force_stall = 0, expect_busy = 0, quiet = 0;

    // Memory, FIFO back-pressure and scoreboard; inputs change at negedge+1, outputs sampled at negedge+2.
    always @(negedge write_clk) begin
        #1;
        cyc++;
        fifo_can_write = force_stall ? 1'b0 : (cw_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        mem_ack = ack_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq[0].addr;
            void'(rq.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = DW'($urandom);
        end
        #1;
        if (!reset) begin
            if (mem_req) check("credit", outstanding < DEPTH, 1);
            if (mem_req && mem_ack) begin
                if (req_idx < exp_addr.size()) check("addr", mem_addr, exp_addr[req_idx]);
                else check("extra_req", req_idx, exp_addr.size());
                req_idx++;
                outstanding++;
                due = cyc + int'($urandom_range(lat_min, lat_max));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq.push_back('{due: due, addr: mem_addr});
            end
            if (quiet) begin
                check("quiet_write", fifo_write, 0);
                check("quiet_done", frame_done, 0);
            end else if (fifo_write) begin
                check("push_can_write", fifo_can_write, 1);
                if (push_idx < exp_addr.size()) check("data", fifo_write_data, exp_addr[push_idx]);
                else check("extra_push", push_idx, exp_addr.size());
                push_idx++;
                outstanding--;
            end
            if (frame_done) begin
                done_count++;
                check("done_busy", busy, 0);
                expect_busy = 0;
            end else if (expect_busy) begin
                check("busy", busy, 1);
            end
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    task automatic build(input logic [AW-1:0] b, input logic [AW-1:0] s);
        int tmp;
        exp_addr.delete();
        for (int yy = 0; yy < LN; yy++)
            for (int xx = 0; xx < WPL; xx++) begin
                tmp = int'(b) + yy * int'(s) + xx;
                exp_addr.push_back(tmp[AW-1:0]);
            end
        req_idx = 0; push_idx = 0; done_count = 0; outstanding = 0; max_out = 0;
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] s);
        @(negedge write_clk);
        base_addr   = b;
        stride      = s;
        frame_start = 1'b1;
        @(negedge write_clk);
        frame_start = 1'b0;
        base_addr   = AW'($urandom);
        stride      = AW'($urandom);
        expect_busy = 1;
    endtask

    task automatic run_frame(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input int lmin, input int lmax,
                             input bit ar, input bit cw, input bit dbl, input bit stall);
        bit timeout;
        lat_min = lmin; lat_max = lmax; ack_rand = ar; cw_rand = cw;
        build(b, s);
        start_frame(b, s);
        timeout = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge write_clk);
            frame_start = dbl && (i == 3 || i == 4);
            if (stall && i == 3) force_stall = 1;
            if (stall && i == 23) begin
                #3;
                check("stall_outstanding", outstanding, DEPTH);
                check("stall_req", mem_req, 0);
                force_stall = 0;
            end
            if (done_count > 0) begin
                timeout = 0;
                break;
            end
        end
        frame_start = 1'b0;
        repeat (3) @(negedge write_clk);
        #3;
        check("timeout", timeout, 0);
        check("pushes", push_idx, N);
        check("reqs", req_idx, N);
        check("done_pulses", done_count, 1);
        check("idle_busy", busy, 0);
        check("drained", outstanding, 0);
        check("max_outstanding", max_out <= DEPTH, 1);
        if (lmin >= 5 && !ar && !cw) check("credits_full", max_out, DEPTH);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_write"}, fifo_write, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge write_clk);
        #3;
        check_reset_outputs("reset");
        reset = 1'b0;

        run_frame(16'h0100, 16'h0010, 1, 1, 0, 0, 0, 0);
        run_frame(16'h0100, 16'h0010, 5, 5, 0, 0, 0, 0);
        run_frame(16'h0100, 16'h0010, 1, 1, 0, 0, 0, 1);
        run_frame(16'hFFFE, 16'h0001, 1, 3, 0, 0, 0, 0);
        run_frame(16'h0100, 16'h0010, 1, 1, 0, 0, 1, 0);

        // Mid-frame reset with three reads still in flight.
        lat_min = 5; lat_max = 5; ack_rand = 0; cw_rand = 0;
        build(16'h0200, 16'h0040);
        start_frame(16'h0200, 16'h0040);
        for (int i = 0; i < 50; i++) begin
            @(negedge write_clk);
            #3;
            if (req_idx >= 3) break;
        end
        check("inflight_before_reset", req_idx, 3);
        @(negedge write_clk);
        reset = 1'b1;
        expect_busy = 0;
        quiet = 1;
        #3;
        check_reset_outputs("midreset");
        repeat (2) @(negedge write_clk);
        reset = 1'b0;
        repeat (12) @(negedge write_clk);
        #3;
        quiet = 0;
        check("stale_drained", rq.size(), 0);

        run_frame(16'h0300, 16'h0020, 1, 1, 0, 0, 0, 0);

        for (int k = 0; k < 6; k++)
            run_frame(AW'($urandom), AW'($urandom), 1, int'($urandom_range(1, 6)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
